// File: rtl/fft_pkg.sv
// Shared types and address helpers for the radix-2 DIT FFT sequencer.
// Latency: n/a (pure functions and types).
// Backpressure: n/a.
package fft_pkg;

  // Widest transform the helper functions can describe (log2 N).
  localparam int MAXW = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    CALC   = 3'd2,
    DRAIN  = 3'd3,
    OUTPUT = 3'd4
  } fft_state_t;

  typedef struct packed {
    logic [MAXW-1:0] a;
    logic [MAXW-1:0] b;
    logic [MAXW-1:0] tw;
  } bfly_t;

  // Reverse the low 'width' bits of value; bits above 'width' must be zero.
  function automatic logic [MAXW-1:0] bitrev(input logic [MAXW-1:0] value, input int width);
    logic [MAXW-1:0] v;
    logic [MAXW-1:0] r;
    v = value;
    r = '0;
    for (int k = 0; k < MAXW; k++) begin
      r = {r[MAXW-2:0], v[0]};
      v = v >> 1;
    end
    return r >> (MAXW - width);
  endfunction

  // Operand pair and twiddle index of butterfly j in stage s. The transform
  // size is passed in so the twiddle index can be scaled to the table size.
  function automatic bfly_t bfly_addr(input int s, input logic [MAXW-1:0] j, input int width);
    logic [MAXW-1:0] half;
    logic [MAXW-1:0] pos;
    bfly_t r;
    half = MAXW'(1) << s;
    pos  = j & (half - MAXW'(1));
    r.a  = ((j >> s) << (s + 1)) | pos;
    r.b  = r.a | half;
    r.tw = pos << (width - 1 - s);
    return r;
  endfunction

endpackage

// File: rtl/fft_delay_line.sv
// Fixed-depth shift register carrying butterfly issue info to writeback.
// Latency: exactly DEPTH cycles, shifts every cycle.
// Backpressure: none; it never stalls.
module fft_delay_line #(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DEPTH*DW-1:0] sr;

  generate
    if (DEPTH == 1) begin : g_one
      // Single-stage delay.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) sr <= '0;
        else      sr <= din;
      end
    end else begin : g_many
      // Shift toward the top; oldest entry sits in the top DW bits.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) sr <= '0;
        else      sr <= {sr[(DEPTH-1)*DW-1:0], din};
      end
    end
  endgenerate

  assign dout = sr[DEPTH*DW-1 -: DW];

endmodule

// File: rtl/fft_sequencer.sv
// Control for an in-place radix-2 DIT FFT: bit-reversed load, WIDTH stages, stream out.
// Latency: WIDTH*(N/2+BFLY_LAT) compute cycles; outputs registered (wr_en = in_valid & in_ready).
// Backpressure: in_valid gaps stall LOAD; out_ready=0 holds out_valid/rd_addr in OUTPUT.
module fft_sequencer
  import fft_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int BFLY_LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             wr_en,
  output logic [WIDTH-1:0] wr_addr,
  output logic             bf_issue,
  output logic [WIDTH-1:0] bf_addr_a,
  output logic [WIDTH-1:0] bf_addr_b,
  output logic [WIDTH-2:0] tw_idx,
  output logic             bf_wb,
  output logic [WIDTH-1:0] wb_addr_a,
  output logic [WIDTH-1:0] wb_addr_b,
  output logic [WIDTH-1:0] rd_addr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  localparam int N   = 1 << WIDTH;
  localparam int TW  = WIDTH - 1;
  localparam int SW  = $clog2(WIDTH);
  localparam int DCW = (BFLY_LAT > 1) ? $clog2(BFLY_LAT) : 1;
  localparam int WBW = 2 * WIDTH + 1;

  localparam logic [WIDTH-1:0] IDX_LAST = WIDTH'(N - 1);
  localparam logic [WIDTH-1:0] J_LAST   = WIDTH'(N / 2 - 1);
  localparam logic [SW-1:0]    S_LAST   = SW'(WIDTH - 1);
  localparam logic [DCW-1:0]   D_LAST   = DCW'(BFLY_LAT - 1);

  fft_state_t       state, state_nxt;
  // idx is the load beat in LOAD, butterfly j in CALC, read address in OUTPUT.
  logic [WIDTH-1:0] idx, idx_nxt;
  logic [SW-1:0]    stg, stg_nxt;
  logic [DCW-1:0]   dcnt, dcnt_nxt;
  logic             ov_nxt;
  logic             last_hs;

  logic             busy_d, done_d, in_ready_d, bf_issue_d, out_last_d;
  logic [WIDTH-1:0] wr_addr_d, bf_addr_a_d, bf_addr_b_d, rd_addr_d;
  logic [TW-1:0]    tw_idx_d;

  bfly_t            ba_nxt;
  logic [WBW-1:0]   wb_bus;

  assign ba_nxt = bfly_addr(int'(stg_nxt), MAXW'(idx_nxt), WIDTH);

  // The write strobe is the load handshake itself; in_ready is a flop, so the
  // only combinational path is from the in_valid input.
  assign wr_en = in_valid & in_ready;

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
      stg   <= '0;
      dcnt  <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      stg   <= stg_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

  // Next-state and counter sequencing.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    stg_nxt   = stg;
    dcnt_nxt  = dcnt;
    ov_nxt    = out_valid;
    last_hs   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD;
          idx_nxt   = '0;
          stg_nxt   = '0;
          dcnt_nxt  = '0;
        end
      end
      LOAD: begin
        if (in_valid && in_ready) begin
          idx_nxt = idx + WIDTH'(1);
          if (idx == IDX_LAST) begin
            state_nxt = CALC;
            idx_nxt   = '0;
          end
        end
      end
      CALC: begin
        if (idx == J_LAST) begin
          state_nxt = DRAIN;
          idx_nxt   = '0;
          dcnt_nxt  = '0;
        end else begin
          idx_nxt = idx + WIDTH'(1);
        end
      end
      DRAIN: begin
        // Wait out the butterfly pipeline so the next stage reads settled data.
        if (dcnt == D_LAST) begin
          dcnt_nxt = '0;
          if (stg == S_LAST) begin
            state_nxt = OUTPUT;
            idx_nxt   = '0;
            ov_nxt    = 1'b0;
          end else begin
            state_nxt = CALC;
            stg_nxt   = stg + SW'(1);
          end
        end else begin
          dcnt_nxt = dcnt + DCW'(1);
        end
      end
      OUTPUT: begin
        // Address first, valid one cycle later to cover the synchronous read.
        if (out_valid) begin
          if (out_ready) begin
            ov_nxt = 1'b0;
            if (idx == IDX_LAST) begin
              state_nxt = IDLE;
              idx_nxt   = '0;
              last_hs   = 1'b1;
            end else begin
              idx_nxt = idx + WIDTH'(1);
            end
          end
        end else begin
          ov_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
        stg_nxt   = '0;
        dcnt_nxt  = '0;
        ov_nxt    = 1'b0;
      end
    endcase
  end

  // Output values decoded from the next state, registered below.
  always_comb begin
    busy_d      = (state_nxt != IDLE);
    done_d      = last_hs;
    in_ready_d  = (state_nxt == LOAD);
    wr_addr_d   = '0;
    bf_issue_d  = (state_nxt == CALC);
    bf_addr_a_d = '0;
    bf_addr_b_d = '0;
    tw_idx_d    = '0;
    rd_addr_d   = '0;
    out_last_d  = 1'b0;
    if (state_nxt == LOAD) begin
      wr_addr_d = WIDTH'(bitrev(MAXW'(idx_nxt), WIDTH));
    end
    if (state_nxt == CALC) begin
      bf_addr_a_d = WIDTH'(ba_nxt.a);
      bf_addr_b_d = WIDTH'(ba_nxt.b);
      tw_idx_d    = TW'(ba_nxt.tw);
    end
    if (state_nxt == OUTPUT) begin
      rd_addr_d  = idx_nxt;
      out_last_d = ov_nxt && (idx_nxt == IDX_LAST);
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      in_ready  <= 1'b0;
      wr_addr   <= '0;
      bf_issue  <= 1'b0;
      bf_addr_a <= '0;
      bf_addr_b <= '0;
      tw_idx    <= '0;
      rd_addr   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      busy      <= busy_d;
      done      <= done_d;
      in_ready  <= in_ready_d;
      wr_addr   <= wr_addr_d;
      bf_issue  <= bf_issue_d;
      bf_addr_a <= bf_addr_a_d;
      bf_addr_b <= bf_addr_b_d;
      tw_idx    <= tw_idx_d;
      rd_addr   <= rd_addr_d;
      out_valid <= ov_nxt;
      out_last  <= out_last_d;
    end
  end

  fft_delay_line #(
    .DEPTH (BFLY_LAT),
    .DW    (WBW)
  ) u_wb_delay (
    .clk  (clk),
    .rst  (rst),
    .din  ({bf_issue, bf_addr_a, bf_addr_b}),
    .dout (wb_bus)
  );

  assign {bf_wb, wb_addr_a, wb_addr_b} = wb_bus;

endmodule

// File: tb/tb_fft_sequencer.sv
// Scoreboard bench for fft_sequencer with WIDTH=3, BFLY_LAT=2.
// Stimulus pushes hand-computed expectations; a negedge monitor pops and compares.
// Inputs change 1 time unit after the rising edge.
module tb_fft_sequencer;

  localparam int W   = 3;
  localparam int LAT = 2;
  localparam int N   = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, in_valid, out_ready;
  logic       busy, done, in_ready, wr_en, bf_issue, bf_wb, out_valid, out_last;
  logic [2:0] wr_addr, bf_addr_a, bf_addr_b, wb_addr_a, wb_addr_b, rd_addr;
  logic [1:0] tw_idx;
  logic [27:0] all_outs;

  always #5 clk = ~clk;

  fft_sequencer #(.WIDTH(W), .BFLY_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .bf_issue(bf_issue), .bf_addr_a(bf_addr_a), .bf_addr_b(bf_addr_b), .tw_idx(tw_idx),
    .bf_wb(bf_wb), .wb_addr_a(wb_addr_a), .wb_addr_b(wb_addr_b), .rd_addr(rd_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  assign all_outs = {busy, done, in_ready, wr_en, wr_addr, bf_issue, bf_addr_a, bf_addr_b,
                     tw_idx, bf_wb, wb_addr_a, wb_addr_b, rd_addr, out_valid, out_last};

  typedef struct packed { logic [2:0] a; logic [2:0] b; logic [1:0] tw; int rel; } iss_t;
  typedef struct packed { logic [2:0] a; logic [2:0] b; int rel; } wb_t;
  typedef struct packed { logic last; logic [2:0] addr; } out_t;

  // Hand-computed reference tables.
  logic [2:0] wr_tab [8]  = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
  logic [2:0] ia_tab [12] = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd0, 3'd1, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3};
  logic [2:0] ib_tab [12] = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd2, 3'd3, 3'd6, 3'd7, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [1:0] tw_tab [12] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3};

  logic [2:0] exp_wr  [$];
  iss_t       exp_iss [$];
  wb_t        exp_wb  [$];
  out_t       exp_out [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int last_hs_cyc = 0;
  bit first_out = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_transform();
    iss_t ie;
    wb_t  we;
    out_t oe;
    for (int k = 0; k < N; k++) exp_wr.push_back(wr_tab[k]);
    for (int k = 0; k < 12; k++) begin
      ie.a   = ia_tab[k];
      ie.b   = ib_tab[k];
      ie.tw  = tw_tab[k];
      ie.rel = (k / 4) * (N / 2 + LAT) + (k % 4);
      exp_iss.push_back(ie);
      we.a   = ia_tab[k];
      we.b   = ib_tab[k];
      we.rel = ie.rel + LAT;
      exp_wb.push_back(we);
    end
    for (int k = 0; k < N; k++) begin
      oe.last = (k == N - 1);
      oe.addr = 3'(k);
      exp_out.push_back(oe);
    end
  endtask

  task automatic do_load(input bit gaps);
    int beats = 0;
    int n = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (beats < N && n < 100) begin
      in_valid = gaps ? (n % 2 == 0) : 1'b1;
      @(negedge clk);
      if (in_valid && in_ready) beats++;
      tick();
      n++;
    end
    in_valid = 1'b0;
    check("load_beats", beats, N);
    @(negedge clk);
    check("in_ready_after_load", int'(in_ready), 0);
    tick();
  endtask

  task automatic run_output(input bit stall);
    bit stalled = 1'b0;
    int n = 0;
    out_ready = 1'b1;
    while (!done && n < 400) begin
      tick();
      n++;
      if (stall && !stalled && out_valid && rd_addr == 3'd3) begin
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("stall_valid", int'(out_valid), 1);
          check("stall_rd_addr", int'(rd_addr), 3);
          check("stall_last", int'(out_last), 0);
          tick();
        end
        out_ready = 1'b1;
        stalled = 1'b1;
      end
    end
    check("done_seen", int'(done), 1);
    check("busy_at_done", int'(busy), 0);
    tick();
    check("done_one_cycle", int'(done), 0);
    check("busy_after_done", int'(busy), 0);
  endtask

  // Cycle counter for timing checks.
  always @(posedge clk) cyc <= cyc + 1;

  iss_t       ei;
  wb_t        ew;
  out_t       eo;
  logic [2:0] junk;

  // Scoreboard monitor: compares every DUT event against the queued expectation.
  always @(negedge clk) begin
    if (rst) begin
      if (in_ready && exp_wr.size() > 0)
        check("wr_addr", int'(wr_addr), int'(exp_wr[0]));
      if (wr_en) begin
        if (exp_wr.size() == 0) check("wr_unexpected", int'(wr_en), 0);
        else junk = exp_wr.pop_front();
      end
      if (bf_issue) begin
        if (exp_iss.size() == 0) check("issue_unexpected", int'(bf_issue), 0);
        else begin
          ei = exp_iss.pop_front();
          if (ei.rel == 0) begin
            t0 = cyc;
            first_out = 1'b1;
          end
          check("bf_addr_a", int'(bf_addr_a), int'(ei.a));
          check("bf_addr_b", int'(bf_addr_b), int'(ei.b));
          check("tw_idx", int'(tw_idx), int'(ei.tw));
          check("issue_cycle", cyc - t0, ei.rel);
        end
      end
      if (bf_wb) begin
        if (exp_wb.size() == 0) check("wb_unexpected", int'(bf_wb), 0);
        else begin
          ew = exp_wb.pop_front();
          check("wb_addr_a", int'(wb_addr_a), int'(ew.a));
          check("wb_addr_b", int'(wb_addr_b), int'(ew.b));
          check("wb_cycle", cyc - t0, ew.rel);
        end
      end
      if (out_valid && first_out) begin
        first_out = 1'b0;
        check("first_out_valid_cycle", cyc - t0, W * (N / 2 + LAT) + 1);
      end
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) check("out_unexpected", int'(out_valid), 0);
        else begin
          eo = exp_out.pop_front();
          check("rd_addr", int'(rd_addr), int'(eo.addr));
          check("out_last", int'(out_last), int'(eo.last));
          if (eo.last) last_hs_cyc = cyc;
        end
      end
      if (done) check("done_cycle", cyc - last_hs_cyc, 1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;

    // Reset held with random inputs: every output must stay zero.
    for (int k = 0; k < 6; k++) begin
      start     = 1'($urandom);
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      @(negedge clk);
      check("reset_outputs_zero", int'(all_outs), 0);
      tick();
    end
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("idle_busy", int'(busy), 0);
      check("idle_in_ready", int'(in_ready), 0);
      tick();
    end

    // Back-to-back load, full compute, free-flowing output.
    push_transform();
    do_load(1'b0);
    run_output(1'b0);

    // Gapped load and a 5-cycle output stall at beat 3.
    push_transform();
    do_load(1'b1);
    run_output(1'b1);

    // Start during CALC is ignored; reset in the middle of stage 1 aborts.
    push_transform();
    do_load(1'b0);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("start_in_calc_ignored", int'(in_ready), 0);
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b0;
    exp_wr.delete();
    exp_iss.delete();
    exp_wb.delete();
    exp_out.delete();
    @(negedge clk);
    check("abort_outputs_zero", int'(all_outs), 0);
    tick();
    tick();
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("post_abort_wb", int'(bf_wb), 0);
      check("post_abort_busy", int'(busy), 0);
      tick();
    end

    // Fresh transform after the abort.
    push_transform();
    do_load(1'b0);
    run_output(1'b0);

    check("queues_drained", exp_wr.size() + exp_iss.size() + exp_wb.size() + exp_out.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
